scan_sequencer: RTL and testbench
=================================

Name: scan_sequencer

Overview:
- Sequences a full cube colour scan: settles the cube, collects and averages RGB sensor samples, feeds them to the colour translator, and writes the returned colour codes into facelet storage.
- Commands the rotation mechanism between positions, then validates the colour histogram.
- Sits between the top-level solve FSM (start/done), the sensor front end, `color_translator`, the motor controller and the cube-state RAM.

Parameters:
- `N_STEPS`, 24, scan positions; each yields one edge and one corner facelet.
- `SETTLE_CYCLES`, 1000, wait after each move before sampling; must be ≥1.
- `SAMPLES_LOG2`, 2, log2 of samples averaged per position.
- `XLATE_WAIT`, 2, cycles from driving translator inputs to capturing its outputs.

Ports:
- `clock` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin scan (sampled only in IDLE).
- `abort` in 1: synchronous abort to IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at scan end.
- `scan_ok` out 1: histogram valid; held until next start.
- `sensor_req` out 1: sample request level.
- `sensor_valid` in 1: one sample present this cycle.
- `r_edge_in`, `g_edge_in`, `b_edge_in`, `r_corner_in`, `g_corner_in`, `b_corner_in` in 8 each: raw sensor values.
- `r_edge`, `g_edge`, `b_edge`, `r_corner`, `g_corner`, `b_corner` out 8 each: registered averages to translator.
- `color_edge`, `color_corner` in 3 each: translator results. Codes: W=0, O=1, G=2, Red=3, Blue=4, Y=5; 6 and 7 are invalid.
- `move_req` out 1: rotate-to-next-position request level.
- `move_done` in 1: one-cycle move completion.
- `wr_en` out 1: facelet write strobe.
- `wr_addr` out 5: facelet index, equal to step.
- `wr_edge_color`, `wr_corner_color` out 3 each: data written.

Behaviour:
- Reset: all outputs 0, state IDLE, step=0, counters and accumulators 0.
- States: IDLE, SETTLE, SAMPLE, AVG, XLATE, WRITE, MOVE, CHECK.
- IDLE: `start`=1 → SETTLE next cycle.
  - Step, 12 colour counters (5 bits each), `bad` flag and `scan_ok` all cleared.
  - `busy` rises the same edge.
- SETTLE: counts exactly `SETTLE_CYCLES` cycles, then → SAMPLE. Accumulators are cleared on entry.
- SAMPLE:
  - `sensor_req` is registered and is 1 from the first SAMPLE cycle.
  - Each cycle with `sensor_valid`=1 adds the six inputs into six (8+`SAMPLES_LOG2`)-bit accumulators.
  - On the 2^`SAMPLES_LOG2`-th valid → AVG; `sensor_req` is 0 next cycle.
  - `sensor_valid` is ignored outside SAMPLE. No timeout.
- AVG (1 cycle): each output register = accumulator >> `SAMPLES_LOG2` (truncating) → XLATE. Output registers hold their value until the next AVG.
- XLATE: waits `XLATE_WAIT` cycles, then → WRITE.
- WRITE (1 cycle):
  - `wr_en`=1, `wr_addr`=step, colour outputs = translator inputs captured this cycle.
  - Increments `edge_cnt[color_edge]` and `corner_cnt[color_corner]`.
  - A code ≥6 sets `bad` instead of incrementing.
  - If step=`N_STEPS`-1 → CHECK; else → MOVE.
- MOVE:
  - `move_req`=1 (registered) until the `move_done` cycle.
  - On `move_done`: step+1, → SETTLE; `move_req` is 0 next cycle.
  - `move_done` is ignored outside MOVE.
- CHECK (1 cycle):
  - `scan_ok` = (!`bad` && every edge_cnt==4 && every corner_cnt==4), valid when `N_STEPS`=24.
  - `done`=1 for this one cycle → IDLE; `busy` falls the next edge.
- `abort`=1 in any non-IDLE state → IDLE next cycle.
  - `sensor_req`, `move_req`, `wr_en` go 0; `done` is not pulsed; `scan_ok` is 0.
  - `abort` overrides `start` and overrides the state's own transition in the same cycle.
- `start` while busy: ignored.
- `reset_n` low mid-scan: immediate return to reset values; no write completes.
- Counters saturate-free: maximum value is 24, which fits in 5 bits.

Test Plan:
- Reset then idle: `reset_n`=0 mid-MOVE → `move_req`, `busy`, `wr_en` all 0 immediately; after release, no activity without `start`.
- Single position timing (`SETTLE_CYCLES`=4, `SAMPLES_LOG2`=2):
  - Stimulus: `start` at cycle 0; valid on 4 consecutive cycles with `r_edge_in`=10,11,12,13.
  - Required: `r_edge`=11 after AVG; `wr_en` with `wr_addr`=0 exactly `XLATE_WAIT`+1 cycles after AVG.
- Handshakes:
  - Gaps in `sensor_valid` → accumulates only valid cycles; `sensor_req` stays high.
  - `move_done` delayed 50 cycles → `move_req` high for 50 cycles; step increments once.
- Full good scan: a translator model returns each colour 4× for edges and 4× for corners over 24 steps → 24 `wr_en` pulses with addresses 0..23, 23 moves, `done` pulse, `scan_ok`=1.
- Bad histogram:
  - Edge colour W returned 5×, O 3× → `done`, `scan_ok`=0.
  - Separate run with one `color_corner`=7 → `scan_ok`=0.
- Abort/start collisions:
  - `abort` asserted during SAMPLE → IDLE next cycle, no `done`.
  - `start` while busy → no restart, step is unchanged.

Source files
------------

// File: rtl/scan_sequencer.sv
// Cube colour scan sequencer: settle, sample/average the RGB sensors, translate, store facelets,
// rotate to the next position, and validate the final colour histogram.
module scan_sequencer #(
  parameter int unsigned N_STEPS       = 24,
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned SAMPLES_LOG2  = 2,
  parameter int unsigned XLATE_WAIT    = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       scan_ok,
  output logic       sensor_req,
  input  logic       sensor_valid,
  input  logic [7:0] r_edge_in,
  input  logic [7:0] g_edge_in,
  input  logic [7:0] b_edge_in,
  input  logic [7:0] r_corner_in,
  input  logic [7:0] g_corner_in,
  input  logic [7:0] b_corner_in,
  output logic [7:0] r_edge,
  output logic [7:0] g_edge,
  output logic [7:0] b_edge,
  output logic [7:0] r_corner,
  output logic [7:0] g_corner,
  output logic [7:0] b_corner,
  input  logic [2:0] color_edge,
  input  logic [2:0] color_corner,
  output logic       move_req,
  input  logic       move_done,
  output logic       wr_en,
  output logic [4:0] wr_addr,
  output logic [2:0] wr_edge_color,
  output logic [2:0] wr_corner_color
);

  localparam int unsigned AccW   = 8 + SAMPLES_LOG2;
  localparam int unsigned SampW  = SAMPLES_LOG2 + 1;
  localparam int unsigned CntMax = (SETTLE_CYCLES > XLATE_WAIT) ? SETTLE_CYCLES : XLATE_WAIT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [SampW-1:0] SampLast   = SampW'((1 << SAMPLES_LOG2) - 1);
  localparam logic [CntW-1:0]  SettleLast = CntW'(SETTLE_CYCLES - 1);
  // XLATE_WAIT is assumed to be at least 1.
  localparam logic [CntW-1:0]  XlateLast  = CntW'(XLATE_WAIT - 1);
  localparam logic [4:0]       StepLast   = 5'(N_STEPS - 1);

  typedef enum logic [2:0] {
    StIdle, StSettle, StSample, StAvg, StXlate, StWrite, StMove, StCheck
  } state_e;

  state_e                 state_q, state_d;
  logic [4:0]             step_q, step_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [SampW-1:0]       samp_q, samp_d;
  logic [5:0][AccW-1:0]   acc_q, acc_d;
  logic [5:0][7:0]        avg_q, avg_d;
  logic [5:0][4:0]        edge_cnt_q, edge_cnt_d;
  logic [5:0][4:0]        corner_cnt_q, corner_cnt_d;
  logic                   bad_q, bad_d;
  logic                   scan_ok_q, scan_ok_d;
  logic                   sensor_req_q, move_req_q;
  logic [5:0][7:0]        sens_in;
  logic                   hist_ok;

  // Channel order: r/g/b edge, then r/g/b corner.
  assign sens_in = {b_corner_in, g_corner_in, r_corner_in, b_edge_in, g_edge_in, r_edge_in};

  always_comb begin
    hist_ok = !bad_q;
    for (int i = 0; i < 6; i++) begin
      if (edge_cnt_q[i] != 5'd4 || corner_cnt_q[i] != 5'd4) hist_ok = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    samp_d       = samp_q;
    acc_d        = acc_q;
    avg_d        = avg_q;
    edge_cnt_d   = edge_cnt_q;
    corner_cnt_d = corner_cnt_q;
    bad_d        = bad_q;
    scan_ok_d    = scan_ok_q;
    wr_en        = 1'b0;
    done         = 1'b0;

    if (abort && state_q != StIdle) begin
      // Abort wins over every state's own transition and suppresses write/done.
      state_d   = StIdle;
      scan_ok_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d      = StSettle;
            step_d       = '0;
            cnt_d        = '0;
            samp_d       = '0;
            acc_d        = '0;
            edge_cnt_d   = '0;
            corner_cnt_d = '0;
            bad_d        = 1'b0;
            scan_ok_d    = 1'b0;
          end
        end
        StSettle: begin
          if (cnt_q == SettleLast) state_d = StSample;
          else                     cnt_d   = cnt_q + CntW'(1);
        end
        StSample: begin
          if (sensor_valid) begin
            for (int i = 0; i < 6; i++) acc_d[i] = acc_q[i] + AccW'(sens_in[i]);
            samp_d = samp_q + SampW'(1);
            if (samp_q == SampLast) state_d = StAvg;
          end
        end
        StAvg: begin
          for (int i = 0; i < 6; i++) avg_d[i] = acc_q[i][SAMPLES_LOG2 +: 8];
          cnt_d   = '0;
          state_d = StXlate;
        end
        StXlate: begin
          if (cnt_q == XlateLast) state_d = StWrite;
          else                    cnt_d   = cnt_q + CntW'(1);
        end
        StWrite: begin
          wr_en = 1'b1;
          for (int i = 0; i < 6; i++) begin
            if (color_edge == 3'(i))   edge_cnt_d[i]   = edge_cnt_q[i] + 5'd1;
            if (color_corner == 3'(i)) corner_cnt_d[i] = corner_cnt_q[i] + 5'd1;
          end
          if (color_edge > 3'd5 || color_corner > 3'd5) bad_d = 1'b1;
          state_d = (step_q == StepLast) ? StCheck : StMove;
        end
        StMove: begin
          if (move_done) begin
            step_d  = step_q + 5'd1;
            cnt_d   = '0;
            samp_d  = '0;
            acc_d   = '0;
            state_d = StSettle;
          end
        end
        StCheck: begin
          done      = 1'b1;
          scan_ok_d = hist_ok;
          state_d   = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      step_q       <= '0;
      cnt_q        <= '0;
      samp_q       <= '0;
      acc_q        <= '0;
      avg_q        <= '0;
      edge_cnt_q   <= '0;
      corner_cnt_q <= '0;
      bad_q        <= 1'b0;
      scan_ok_q    <= 1'b0;
      sensor_req_q <= 1'b0;
      move_req_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      samp_q       <= samp_d;
      acc_q        <= acc_d;
      avg_q        <= avg_d;
      edge_cnt_q   <= edge_cnt_d;
      corner_cnt_q <= corner_cnt_d;
      bad_q        <= bad_d;
      scan_ok_q    <= scan_ok_d;
      sensor_req_q <= (state_d == StSample);
      move_req_q   <= (state_d == StMove);
    end
  end

  assign busy            = (state_q != StIdle);
  assign scan_ok         = scan_ok_q;
  assign sensor_req      = sensor_req_q;
  assign move_req        = move_req_q;
  assign wr_addr         = step_q;
  assign wr_edge_color   = wr_en ? color_edge : 3'd0;
  assign wr_corner_color = wr_en ? color_corner : 3'd0;
  assign r_edge          = avg_q[0];
  assign g_edge          = avg_q[1];
  assign b_edge          = avg_q[2];
  assign r_corner        = avg_q[3];
  assign g_corner        = avg_q[4];
  assign b_corner        = avg_q[5];

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: a sensor/motor responder plus a translator model that maps
// the averaged red channel straight to a colour code.
module tb_scan_sequencer;

  localparam int unsigned NSteps = 24;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       sensor_valid = 1'b0;
  logic       move_done = 1'b0;
  logic [7:0] r_edge_in = '0, g_edge_in = '0, b_edge_in = '0;
  logic [7:0] r_corner_in = '0, g_corner_in = '0, b_corner_in = '0;
  logic       busy, done, scan_ok, sensor_req, move_req, wr_en;
  logic [7:0] r_edge, g_edge, b_edge, r_corner, g_corner, b_corner;
  logic [2:0] color_edge, color_corner, wr_edge_color, wr_corner_color;
  logic [4:0] wr_addr;

  // Responder controls, written by the main sequence.
  bit         ramp_en = 1'b1;
  bit         gap_en = 1'b0;
  int         move_delay = 50;
  logic [7:0] edge_tab [NSteps];
  logic [7:0] corner_tab [NSteps];

  int n_checks = 0;
  int n_fail = 0;

  // Responder-private state.
  int rs_pos = 0;
  int rs_sidx = 0;
  int rs_mcnt = 0;
  bit rs_ph = 1'b0;

  assign color_edge   = r_edge[2:0];
  assign color_corner = r_corner[2:0];

  scan_sequencer #(
    .N_STEPS      (NSteps),
    .SETTLE_CYCLES(4),
    .SAMPLES_LOG2 (2),
    .XLATE_WAIT   (2)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .scan_ok        (scan_ok),
    .sensor_req     (sensor_req),
    .sensor_valid   (sensor_valid),
    .r_edge_in      (r_edge_in),
    .g_edge_in      (g_edge_in),
    .b_edge_in      (b_edge_in),
    .r_corner_in    (r_corner_in),
    .g_corner_in    (g_corner_in),
    .b_corner_in    (b_corner_in),
    .r_edge         (r_edge),
    .g_edge         (g_edge),
    .b_edge         (b_edge),
    .r_corner       (r_corner),
    .g_corner       (g_corner),
    .b_corner       (b_corner),
    .color_edge     (color_edge),
    .color_corner   (color_corner),
    .move_req       (move_req),
    .move_done      (move_done),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_edge_color  (wr_edge_color),
    .wr_corner_color(wr_corner_color)
  );

  initial forever #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return sensor_req;
      1:       return move_req;
      default: return wr_en;
    endcase
  endfunction

  // Bounded wait at negedges for sensor_req (0), move_req (1) or wr_en (2).
  task automatic wait_for(input int sel, input string tag);
    int n = 0;
    while (!pick(sel) && n < 500) begin
      n++;
      @(negedge clock);
    end
    check_eq({tag, "_seen"}, 32'(pick(sel)), 32'd1);
  endtask

  // Sensor and motor responder; invalid sensor cycles carry 0xFF so stray accumulation shows.
  initial forever begin
    @(negedge clock);
    if (!busy) rs_pos = 0;
    if (sensor_req) begin
      sensor_valid = gap_en ? rs_ph : 1'b1;
      rs_ph = !rs_ph;
      if (sensor_valid) begin
        if (ramp_en) begin
          r_edge_in   = 8'(10 + rs_sidx);
          g_edge_in   = 8'(200 + rs_sidx);
          b_edge_in   = 8'(250 + rs_sidx);
          r_corner_in = 8'(3 + rs_sidx);
          g_corner_in = 8'd100;
          b_corner_in = 8'd7;
        end else begin
          r_edge_in   = edge_tab[rs_pos];
          r_corner_in = corner_tab[rs_pos];
          g_edge_in   = 8'h40;
          b_edge_in   = 8'h40;
          g_corner_in = 8'h40;
          b_corner_in = 8'h40;
        end
        rs_sidx++;
      end else begin
        {r_edge_in, g_edge_in, b_edge_in} = {3{8'hFF}};
        {r_corner_in, g_corner_in, b_corner_in} = {3{8'hFF}};
      end
    end else begin
      sensor_valid = 1'b0;
      rs_sidx = 0;
      rs_ph = 1'b0;
    end
    if (move_req) begin
      rs_mcnt++;
      move_done = (rs_mcnt == move_delay);
      if (move_done) rs_pos++;
    end else begin
      rs_mcnt = 0;
      move_done = 1'b0;
    end
  end

  task automatic run_scan(input bit exp_ok, input string tag);
    int  nwr = 0;
    int  nmv = 0;
    int  guard = 0;
    bit  prev_mv = 1'b0;
    bit  seen_done = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_eq({tag, "_okclr"}, 32'(scan_ok), 32'd0);
    while (!seen_done && guard < 3000) begin
      if (wr_en) begin
        if (nwr < int'(NSteps))
          check_eq({tag, "_wr"}, {wr_addr, wr_edge_color, wr_corner_color},
                   {5'(nwr), edge_tab[nwr][2:0], corner_tab[nwr][2:0]});
        nwr++;
      end
      if (move_req && !prev_mv) nmv++;
      prev_mv = move_req;
      if (done) seen_done = 1'b1;
      guard++;
      @(negedge clock);
    end
    check_eq({tag, "_done"}, 32'(seen_done), 32'd1);
    check_eq({tag, "_nwr"}, 32'(nwr), 32'd24);
    check_eq({tag, "_nmove"}, 32'(nmv), 32'd23);
    check_eq({tag, "_scanok"}, 32'(scan_ok), 32'(exp_ok));
    check_eq({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int lo, hi, n, act;
    for (int i = 0; i < int'(NSteps); i++) begin
      edge_tab[i]   = 8'(i % 6);
      corner_tab[i] = 8'(i / 4);
    end

    // Reset values.
    repeat (3) @(negedge clock);
    check_eq("reset_ctl", {26'd0, busy, done, scan_ok, sensor_req, move_req, wr_en}, 32'd0);
    check_eq("reset_avg", {r_edge, g_edge, b_edge, 3'd0, wr_addr}, 32'd0);
    reset_n = 1'b1;
    act = 0;
    repeat (5) begin
      @(negedge clock);
      if (busy || sensor_req || move_req || wr_en) act++;
    end
    check_eq("idle_quiet", 32'(act), 32'd0);

    // Single position with ramped samples and a 50-cycle move.
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_eq("busy_rise", 32'(busy), 32'd1);
    lo = 0;
    while (!sensor_req && lo < 100) begin lo++; @(negedge clock); end
    check_eq("settle_len", 32'(lo), 32'd4);
    hi = 0;
    while (sensor_req && hi < 100) begin hi++; @(negedge clock); end
    check_eq("req_len", 32'(hi), 32'd4);
    n = 0;
    while (!wr_en && n < 100) begin n++; @(negedge clock); end
    check_eq("avg_to_wr", 32'(n), 32'd3);
    check_eq("wr_addr0", 32'(wr_addr), 32'd0);
    check_eq("avg_edge", {8'd0, r_edge, g_edge, b_edge}, {8'd0, 8'd11, 8'd201, 8'd251});
    check_eq("avg_corner", {8'd0, r_corner, g_corner, b_corner}, {8'd0, 8'd4, 8'd100, 8'd7});
    check_eq("wr_colors", {wr_edge_color, wr_corner_color}, {3'd3, 3'd4});
    @(negedge clock);
    wait_for(1, "move0");
    hi = 0;
    while (move_req && hi < 200) begin hi++; @(negedge clock); end
    check_eq("move_len", 32'(hi), 32'd50);

    // Position 1: valid every other cycle.
    gap_en = 1'b1;
    move_delay = 1;
    wait_for(0, "gap_req");
    hi = 0;
    while (sensor_req && hi < 100) begin hi++; @(negedge clock); end
    check_eq("gap_req_len", 32'(hi), 32'd8);
    wait_for(2, "gap_wr");
    check_eq("gap_wr_addr", 32'(wr_addr), 32'd1);
    check_eq("gap_avg", {16'd0, r_edge, b_edge}, {16'd0, 8'd11, 8'd251});
    gap_en = 1'b0;

    // Start while busy is ignored; step keeps counting.
    wait_for(1, "busy_move");
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_for(2, "restart_wr");
    check_eq("restart_step", 32'(wr_addr), 32'd2);

    // Abort during SAMPLE.
    wait_for(0, "abort_req");
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check_eq("abort_idle", {29'd0, busy, sensor_req, move_req}, 32'd0);
    act = 0;
    repeat (30) begin
      if (done || busy) act++;
      @(negedge clock);
    end
    check_eq("abort_quiet", 32'(act), 32'd0);
    check_eq("abort_scanok", 32'(scan_ok), 32'd0);

    // Full scans through the translator model.
    ramp_en = 1'b0;
    move_delay = 2;
    run_scan(1'b1, "good");
    edge_tab[1] = 8'd0;
    run_scan(1'b0, "bad_edge");
    edge_tab[1] = 8'd1;
    corner_tab[5] = 8'd7;
    run_scan(1'b0, "bad_corner");
    corner_tab[5] = 8'd1;

    // Asynchronous reset mid-MOVE.
    move_delay = 1000;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_for(1, "rst_move");
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_eq("rst_async", {29'd0, move_req, busy, wr_en}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    act = 0;
    repeat (10) begin
      @(negedge clock);
      if (busy || sensor_req || move_req || wr_en || done) act++;
    end
    check_eq("rst_quiet", 32'(act), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
